fp_mac: RTL and testbench
=========================

// Module: fp_mac
// PURPOSE
//  IEEE-754 single-precision multiply-accumulate: each clock, MacOut <= MacOut + In1*In2.
//  Single-cycle datapath with one accumulator register, which drives MacOut directly.
//  Used as a streaming dot-product engine. Software clears it with rst between vectors.
// PARAMETERS
//  none (format fixed at binary32: 1 sign, 8 exponent (bias 127), 23 fraction)
// PORTS
//  CLK     in   1   clock; all state updates on rising edge
//  rst     in   1   reset; synchronous, active-high; clears accumulator
//  In1     in   32  multiplicand, binary32
//  In2     in   32  multiplier, binary32
//  MacOut  out  32  accumulator value, binary32, registered
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous and active-high (rst sampled on CLK rising edge).
//  - Reset: acc <= 32'h0000_0000 (+0.0). rst overrides accumulation in the same edge.
//  - Otherwise every edge: acc <= round(acc + round(In1*In2)).
//    - Not fused: the product is first rounded to binary32 (RNE), then the sum is rounded (RNE).
//  - Latency: inputs sampled at edge N appear in MacOut after edge N. No handshake; accumulates every cycle.
//  - To hold the value, drive In1 or In2 with +0.0.
//  - Multiply: sign = s1^s2, exp = e1+e2-127, 24x24 significand product, normalise 1 bit, RNE.
//  - Add: align the smaller operand, keeping guard/round/sticky bits.
//    - Effective subtract: leading-zero normalise.
//    - RNE, then renormalise on mantissa carry-out.
//  - Subnormals: inputs with exp==0 are treated as signed zero (flush-to-zero).
//    Results below 2^-126 become signed zero.
//  - Zero sign: exact cancellation (x + -x) gives +0.
//    +0 + -0 = +0; -0 + -0 = -0.
//  - Overflow (exp >= 255 after rounding) gives +/-inf (32'h7F80_0000 / 32'hFF80_0000).
//  - Special operands:
//    - NaN in any operand, inf*0, and inf + -inf give canonical qNaN 32'h7FC0_0000.
//    - inf*finite(nonzero) gives signed inf. inf + finite gives that inf.
//  - Once acc holds NaN/inf it stays so until rst or an operation that changes it per IEEE rules.
//  - No exception flags are output.
// CONFIGURATION
//  FP_MAC_SAT_EN
//   - Defined: overflow saturates to the signed max finite value, +/-32'h7F7F_FFFF, instead of inf.
//     Inf/NaN operands still follow the rules above.
//   - Undefined (default): overflow produces +/-inf.
// TESTING
//  1. rst=1 for one edge -> MacOut=32'h0000_0000.
//  2. Continue from test 1. rst=0, then three consecutive edges:
//     - In1=3FC00000 (1.5), In2=40200000 (2.5) -> MacOut=40700000 (3.75).
//     - In1=3F000000, In2=C0800000 (0.5*-4) -> MacOut=3FE00000 (1.75).
//     - In1=41280000 (10.5), In2=3DCCCCCD -> MacOut=40333334.
//       The product rounds to 3F866667 and the sum is an RNE tie.
//  3. rst=1 with In1=40E00000 (7), In2=40400000 (3) -> MacOut=00000000.
//     Then rst=0 for one edge with the same inputs -> 41A80000 (21).
//  4. Steady-state operands:
//     - From acc=+0: In1=7F800000, In2=3F800000 -> 7F800000.
//       Next edge In1=FF800000, In2=3F800000 -> 7FC00000.
//     - From acc=+0: In1=7F800000, In2=0 -> 7FC00000.
//  5. From acc=+0: In1=7F7FFFFF, In2=40000000 -> 7F800000.
//     With FP_MAC_SAT_EN defined -> 7F7FFFFF.
//  6. From acc=+0: In1=00400000 (subnormal), In2=3F800000 -> 00000000.
//     Then In1=3F800000, In2=3F800000 -> 3F800000. Then In1=BF800000, In2=3F800000 -> 00000000 (+0).

Source files
------------

// File: rtl/fp_mac.sv
// fp_mac: binary32 multiply-accumulate, acc <= round(acc + round(In1*In2)).
// Product and sum are rounded separately (RNE); subnormal inputs and tiny
// results flush to signed zero. Define FP_MAC_SAT_EN to saturate overflow to
// the largest finite magnitude instead of producing infinity.
module fp_mac (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic [31:0] MacOut
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // m: bit 26 = leading one, [25:3] fraction, [2] guard, [1] round, [0] sticky
    function automatic logic [31:0] round_pack(input logic sign,
                                               input logic signed [9:0] exp,
                                               input logic [26:0] m);
        logic              inc;
        logic [24:0]       r;
        logic signed [9:0] e;
        inc = m[2] & (m[1] | m[0] | m[3]);
        r   = {1'b0, m[26:3]} + {24'd0, inc};
        e   = exp;
        if (r[24]) e = e + 10'sd1;
        if (e >= 10'sd255) begin
`ifdef FP_MAC_SAT_EN
            round_pack = {sign, 31'h7F7F_FFFF};
`else
            round_pack = {sign, 8'hFF, 23'd0};
`endif
        end else if (e <= 10'sd0) begin
            round_pack = {sign, 31'd0};
        end else begin
            round_pack = {sign, e[7:0], r[22:0]};
        end
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    logic [31:0] acc;

    // Operand classification (exp==0 is treated as zero)
    logic z1, z2, i1, i2, n1, n2;
    assign z1 = (In1[30:23] == 8'd0);
    assign z2 = (In2[30:23] == 8'd0);
    assign i1 = (&In1[30:23]) & ~(|In1[22:0]);
    assign i2 = (&In2[30:23]) & ~(|In2[22:0]);
    assign n1 = (&In1[30:23]) & (|In1[22:0]);
    assign n2 = (&In2[30:23]) & (|In2[22:0]);

    logic              psign;
    logic [47:0]       prod;
    logic [26:0]       pm;
    logic signed [9:0] pexp;
    logic [31:0]       p;

    // Multiplier: product rounded to binary32 before accumulation
    always_comb begin
        psign = In1[31] ^ In2[31];
        prod  = {24'd0, 1'b1, In1[22:0]} * {24'd0, 1'b1, In2[22:0]};
        pexp  = $signed({2'b00, In1[30:23]}) + $signed({2'b00, In2[30:23]}) - 10'sd127;
        if (prod[47]) begin
            pm   = {prod[47:22], |prod[21:0]};
            pexp = pexp + 10'sd1;
        end else begin
            pm   = {prod[46:21], |prod[20:0]};
        end
        if (n1 | n2 | (i1 & z2) | (i2 & z1)) p = QNAN;
        else if (i1 | i2)                    p = {psign, 8'hFF, 23'd0};
        else if (z1 | z2)                    p = {psign, 31'd0};
        else                                 p = round_pack(psign, pexp, pm);
    end

    logic za, zb, ia, ib, na, nb;
    assign za = (acc[30:23] == 8'd0);
    assign zb = (p[30:23] == 8'd0);
    assign ia = (&acc[30:23]) & ~(|acc[22:0]);
    assign ib = (&p[30:23]) & ~(|p[22:0]);
    assign na = (&acc[30:23]) & (|acc[22:0]);
    assign nb = (&p[30:23]) & (|p[22:0]);

    logic [31:0]       op_big, op_small;
    logic [7:0]        d;
    logic [4:0]        dc, lz;
    logic [56:0]       wide;
    logic [26:0]       bm, al, am, diff;
    logic [27:0]       sum;
    logic signed [9:0] aexp;
    logic              cancel;
    logic [31:0]       nxt;

    // Adder: align smaller magnitude with sticky, add/subtract, normalise, round
    always_comb begin
        if (acc[30:0] >= p[30:0]) begin
            op_big   = acc;
            op_small = p;
        end else begin
            op_big   = p;
            op_small = acc;
        end
        d    = op_big[30:23] - op_small[30:23];
        // Shifts of 30 or more all land in the sticky bit, so the distance is capped
        dc   = (d > 8'd30) ? 5'd30 : d[4:0];
        wide = {1'b1, op_small[22:0], 3'b000, 30'd0} >> dc;
        al   = {wide[56:31], wide[30] | (|wide[29:0])};
        bm   = {1'b1, op_big[22:0], 3'b000};
        sum  = '0;
        diff = '0;
        lz   = '0;
        cancel = 1'b0;
        if (op_big[31] == op_small[31]) begin
            sum = {1'b0, bm} + {1'b0, al};
            if (sum[27]) begin
                am   = {sum[27:2], sum[1] | sum[0]};
                aexp = $signed({2'b00, op_big[30:23]}) + 10'sd1;
            end else begin
                am   = sum[26:0];
                aexp = $signed({2'b00, op_big[30:23]});
            end
        end else begin
            diff   = bm - al;
            cancel = (diff == 27'd0);
            lz     = lzc27(diff);
            am     = diff << lz;
            aexp   = $signed({2'b00, op_big[30:23]}) - $signed({5'd0, lz});
        end
        if (na | nb | (ia & ib & (acc[31] != p[31]))) nxt = QNAN;
        else if (ia)                                  nxt = {acc[31], 8'hFF, 23'd0};
        else if (ib)                                  nxt = {p[31], 8'hFF, 23'd0};
        else if (za & zb)                             nxt = {acc[31] & p[31], 31'd0};
        else if (za)                                  nxt = p;
        else if (zb)                                  nxt = acc;
        else if (cancel)                              nxt = '0;
        else                                          nxt = round_pack(op_big[31], aexp, am);
    end

    // Accumulator register; reset wins over accumulation
    always_ff @(posedge CLK) begin
        if (rst) acc <= '0;
        else     acc <= nxt;
    end

    assign MacOut = acc;

endmodule

// File: tb/tb_fp_mac.sv
// Self-checking bench for fp_mac: directed vectors, expected results queued
// when stimulus is applied and compared one edge later.
module tb_fp_mac;

    logic        CLK;
    logic        rst;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [31:0] MacOut;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

`ifdef FP_MAC_SAT_EN
    localparam logic [31:0] POS_OVF = 32'h7F7F_FFFF;
    localparam logic [31:0] NEG_OVF = 32'hFF7F_FFFF;
`else
    localparam logic [31:0] POS_OVF = 32'h7F80_0000;
    localparam logic [31:0] NEG_OVF = 32'hFF80_0000;
`endif

    fp_mac dut (
        .CLK    (CLK),
        .rst    (rst),
        .In1    (In1),
        .In2    (In2),
        .MacOut (MacOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic r, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.e = e;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, settle after the edge
    task automatic apply(input logic r, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
        rst = r;
        In1 = a;
        In2 = b;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] want;
        apply(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
        want = exp_q.pop_front();
        checks++;
        if (MacOut !== want) begin
            errors++;
            $display("FAIL reset MacOut=%h expected=%h", MacOut, want);
        end
    endtask

    task automatic test_accumulate();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b0, 32'h3FC0_0000, 32'h4020_0000, 32'h4070_0000));
        v.push_back(mk(1'b0, 32'h3F00_0000, 32'hC080_0000, 32'h3FE0_0000));
        v.push_back(mk(1'b0, 32'h4128_0000, 32'h3DCC_CCCD, 32'h4033_3334));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL accumulate[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_reset_priority();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b1, 32'h40E0_0000, 32'h4040_0000, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h40E0_0000, 32'h4040_0000, 32'h41A8_0000));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL reset_priority[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_specials();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000));
        v.push_back(mk(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000));
        v.push_back(mk(1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000));
        v.push_back(mk(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000));
        v.push_back(mk(1'b0, 32'h4000_0000, 32'h0000_0000, 32'hFF80_0000));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL specials[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h7F7F_FFFF, 32'h4000_0000, POS_OVF));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'hFF7F_FFFF, 32'h4000_0000, NEG_OVF));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF));
        v.push_back(mk(1'b0, 32'h7F7F_FFFF, 32'h3F80_0000, POS_OVF));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL overflow[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_ftz_zero_sign();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000));
        v.push_back(mk(1'b0, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h8000_0000, 32'h3F80_0000, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h80C0_0000, 32'h3F80_0000, 32'h80C0_0000));
        v.push_back(mk(1'b0, 32'h0080_0000, 32'h3F80_0000, 32'h8000_0000));
        v.push_back(mk(1'b0, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL ftz_zero_sign[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_rounding();
        vec_t v[$];
        logic [31:0] want;
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002));
        v.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0000_0000));
        v.push_back(mk(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000));
        v.push_back(mk(1'b0, 32'h3380_0000, 32'h3F80_0000, 32'h3F80_0000));
        v.push_back(mk(1'b0, 32'h3380_0001, 32'h3F80_0000, 32'h3F80_0001));
        v.push_back(mk(1'b0, 32'h3380_0000, 32'h3F80_0000, 32'h3F80_0002));
        v.push_back(mk(1'b0, 32'hBF80_0000, 32'h3F80_0000, 32'h3480_0000));
        foreach (v[i]) begin
            apply(v[i].r, v[i].a, v[i].b, v[i].e);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL rounding[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        logic [31:0] counts [8];
        counts = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        apply(1'b1, 32'h0, 32'h0, 32'h0000_0000);
        want = exp_q.pop_front();
        checks++;
        if (MacOut !== want) begin
            errors++;
            $display("FAIL back_to_back_rst MacOut=%h expected=%h", MacOut, want);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 32'h3F80_0000, 32'h3F80_0000, counts[i]);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h4120_0000, 32'h0000_0000, 32'h4100_0000);
            want = exp_q.pop_front();
            checks++;
            if (MacOut !== want) begin
                errors++;
                $display("FAIL hold[%0d] MacOut=%h expected=%h", i, MacOut, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        In1 = '0;
        In2 = '0;
        test_reset();
        test_accumulate();
        test_reset_priority();
        test_specials();
        test_overflow();
        test_ftz_zero_sign();
        test_rounding();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
